// File: rtl/horner_operative.sv
// horner_operative: evaluates c[N-1]*x^(N-1)+...+c[0] by Horner's rule on one shared
// multiply/add ALU, with its own start/busy/done sequencer.
module horner_operative #(
    parameter int WIDTH = 16,
    parameter int NCOEF = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x,
    input  logic [NCOEF*WIDTH-1:0] coef,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   ovf
);
    localparam int IW = (NCOEF > 2) ? $clog2(NCOEF - 1) : 1;
    localparam logic [IW-1:0] I_START = IW'((NCOEF > 1) ? NCOEF - 2 : 0);
    typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_x, r_s, r_h, r_result;
    logic [IW-1:0] r_idx;
    logic [NCOEF*WIDTH-1:0] r_coef;
    logic r_busy, r_done, r_ovf;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0] w_sum;
    assign w_prod = {{WIDTH{1'b0}}, r_s} * {{WIDTH{1'b0}}, r_x};
    assign w_sum = {1'b0, r_h} + {1'b0, r_coef[int'(r_idx)*WIDTH +: WIDTH]};
    assign busy = r_busy;
    assign done = r_done;
    assign result = r_result;
    assign ovf = r_ovf;
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? ((start && NCOEF > 1) ? MUL : IDLE) :
                 (r_state == MUL)  ? ADD :
                 (r_idx == '0)     ? IDLE : MUL;
    end
    // A single-coefficient build completes on the accept edge without ever going busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_s <= '0;
            r_h <= '0;
            r_idx <= '0;
            r_coef <= '0;
            r_result <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_coef <= coef;
                    r_x <= x;
                    r_s <= coef[(NCOEF-1)*WIDTH +: WIDTH];
                    r_idx <= I_START;
                    r_ovf <= 1'b0;
                    r_busy <= (NCOEF > 1);
                    if (NCOEF == 1) begin
                        r_done <= 1'b1;
                        r_result <= coef[(NCOEF-1)*WIDTH +: WIDTH];
                    end
                end
                MUL: begin
                    r_h <= w_prod[WIDTH-1:0];
                    r_ovf <= r_ovf | (|w_prod[2*WIDTH-1:WIDTH]);
                end
                ADD: begin
                    r_s <= w_sum[WIDTH-1:0];
                    r_ovf <= r_ovf | w_sum[WIDTH];
                    if (r_idx == '0) begin
                        r_result <= w_sum[WIDTH-1:0];
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_horner_operative.sv
// tb_horner_operative: scoreboard bench for horner_operative (NCOEF=3 and NCOEF=1 builds).
module tb_horner_operative;
    localparam int W = 16;
    localparam int N = 3;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
    logic [W-1:0] x = '0, x1 = '0, coef1 = '0;
    logic [N*W-1:0] coef = '0;
    logic busy, done, ovf, busy1, done1, ovf1;
    logic [W-1:0] result, result1;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct {logic [W-1:0] res; logic ovf; int cyc;} exp_t;
    exp_t q[$];
    logic [W-1:0] last_res = '0;

    horner_operative #(.WIDTH(W), .NCOEF(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .coef(coef),
        .busy(busy), .done(done), .result(result), .ovf(ovf));
    horner_operative #(.WIDTH(W), .NCOEF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .coef(coef1),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] xv, input logic [N*W-1:0] cv, input int c);
        logic [2*W-1:0] p;
        logic [W:0] t;
        logic [W-1:0] s;
        exp_t e;
        s = cv[(N-1)*W +: W];
        e.ovf = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            p = {{W{1'b0}}, s} * {{W{1'b0}}, xv};
            if (p[2*W-1:W] != 0) e.ovf = 1'b1;
            t = {1'b0, p[W-1:0]} + {1'b0, cv[i*W +: W]};
            if (t[W]) e.ovf = 1'b1;
            s = t[W-1:0];
        end
        e.res = s;
        e.cyc = c;
        return e;
    endfunction

    // Called on a falling edge; the accept is the next rising edge, done is seen 5 falling edges on.
    task automatic launch(input logic [W-1:0] xv, input logic [N*W-1:0] cv);
        x = xv;
        coef = cv;
        start = 1'b1;
        q.push_back(model(xv, cv, cyc + 5));
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("done_pending", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("ovf", ovf, e.ovf);
                chk("latency", cyc, e.cyc);
                last_res = e.res;
            end
        end
    end

    task automatic eval(input logic [W-1:0] xv, input logic [N*W-1:0] cv, input bit iso);
        @(negedge clk);
        launch(xv, cv);
        @(negedge clk);
        start = 1'b0;
        chk("ovf_clr", ovf, 0);
        chk("result_hold", result, last_res);
        chk("busy", busy, 1);
        if (iso) begin
            x = '1;
            coef = '1;
        end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            start = iso && (i == 2);
            chk("busy", busy, 1);
        end
        @(negedge clk);
        chk("busy_fall", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_result1", result1, 0);
        chk("rst_done1", done1, 0);
        rst_n = 1'b1;
        eval(16'd4, {16'd2, 16'd3, 16'd5}, 0);
        eval(16'd256, {16'd256, 16'd0, 16'd1}, 0);
        eval(16'd0, {16'd256, 16'd0, 16'd1}, 0);
        eval(16'd4, {16'd2, 16'd3, 16'd5}, 1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom};
            launch((k % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom), r[N*W-1:0]);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (k == 3 && j == 0) start = 1'b0;
                r = {$urandom, $urandom};
                x = W'($urandom);
                coef = r[N*W-1:0];
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        x = 16'd4;
        coef = {16'd2, 16'd3, 16'd5};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_ovf", ovf, 0);
        @(negedge clk);
        chk("rst_start_ignored", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        last_res = '0;
        repeat (6) @(negedge clk);
        chk("no_done_after_rst", busy, 0);
        eval(16'd3, {16'd1, 16'd1, 16'd1}, 0);
        coef1 = 16'h1234;
        x1 = 16'h00aa;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_done", done1, 1);
        chk("n1_result", result1, 16'h1234);
        chk("n1_busy", busy1, 0);
        chk("n1_ovf", ovf1, 0);
        @(negedge clk);
        chk("n1_done_pulse", done1, 0);
        chk("n1_busy_idle", busy1, 0);
        chk("n1_result_hold", result1, 16'h1234);
        repeat (2) @(negedge clk);
        chk("pending", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/horner_operative.md
# horner_operative

Parametrised operative unit with its own sequencer. It evaluates the polynomial c[N-1]·x^(N-1) + … + c[1]·x + c[0] by Horner's rule on one shared ALU, using registers X, S and H in the same way as the existing operative datapath. The datapath is generalised to WIDTH bits and NCOEF coefficients. Sequencing is internal, with a start/busy/done handshake, so no external control unit drives the register loads or mux selects.

## Interface
- WIDTH, 16: datapath width in bits for x, every coefficient, the X/S/H registers and result; minimum 2.
- NCOEF, 3: number of coefficients, range 1..16; the polynomial degree is NCOEF-1.
- clk  input  1  rising-edge clock; the block uses only this clock.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- start  input  1  request an evaluation; sampled only in IDLE.
- x  input  WIDTH  evaluation point; captured into X when start is accepted.
- coef  input  NCOEF*WIDTH  coefficient bus; c[i] = coef[i*WIDTH +: WIDTH]; captured into the internal coefficient file when start is accepted.
- busy  output  1  high while an evaluation is in progress.
- done  output  1  one-cycle pulse; result and ovf are valid from this cycle onward.
- result  output  WIDTH  final S value; held until the next accepted start or reset.
- ovf  output  1  sticky flag for the current evaluation: set if any step overflowed; held with result.

## Operation
- States: IDLE, MUL, ADD.
- ALU functions: multiply, H ← (S·X) mod 2^WIDTH; add, S ← (H + c[i]) mod 2^WIDTH. All arithmetic is unsigned.
- A multiply overflows when the upper WIDTH bits of the full 2·WIDTH product are nonzero. An add overflows when there is a carry out of bit WIDTH-1.
- IDLE with start=1 (accept):
  - capture all NCOEF coefficients; X ← x; S ← c[NCOEF-1]; index i ← NCOEF-2; ovf ← 0; busy ← 1.
  - next state is MUL. If NCOEF=1, the block finishes immediately instead: done ← 1 with result = c[0], and it stays in IDLE.
- MUL: H ← S·X; ovf is set on overflow; next state is ADD.
- ADD: S ← H + c[i]; ovf is set on overflow.
  - if i > 0: i ← i-1; next state is MUL.
  - if i = 0: result ← new S; done ← 1; busy ← 0; next state is IDLE.
- IDLE with start=0: nothing changes, and done returns to 0.
- start while busy=1 is ignored. It is neither queued nor an error.
- x and coef may change freely after acceptance; an evaluation in progress uses only the captured copies.
- Back-to-back evaluations: start high in the done cycle is accepted, because the FSM is already in IDLE.
- result and ovf change only on an accepted start (ovf clears, result is untouched) and on completion.
- Reset (rst_n=0 at an edge), including mid-evaluation:
  - state ← IDLE.
  - busy, done, ovf ← 0; result, X, S, H, i and the coefficient file ← 0.
  - the interrupted evaluation is abandoned and no done pulse is produced.
- Reset has priority over start on the same edge.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Accept edge k, with NCOEF ≥ 2: busy is high from edge k. done=1 and the valid result appear after edge k + 2·(NCOEF-1), the same edge at which busy falls.
- Latency from accept to done is 2·(NCOEF-1) cycles; NCOEF=3 gives 4 cycles.
- NCOEF=1: done appears after the accept edge, and busy never rises.
- done is high for exactly one cycle per accepted start.
- Throughput with back-to-back starts: one result per 2·(NCOEF-1)+1 cycles.

## Test plan
- Basic evaluation: WIDTH=16, NCOEF=3, c2=2, c1=3, c0=5, x=4, start pulse at edge k -> busy high for 4 cycles; done after edge k+4; result=49, ovf=0.
- Overflow: c2=256, c1=0, c0=1, x=256 -> first multiply product 65536 truncates to 0; result=1, ovf=1. Then a following start with x=0 -> ovf clears at the accept edge, result=1 (0·… + 1).
- Input isolation and busy handling: change coef and x to 0xFFFF one cycle after accept, and pulse start while busy -> result is still 49; no second evaluation runs; exactly one done pulse.
- Back-to-back: start held high continuously -> done pulses every 5 cycles, and each result matches the inputs captured at its own accept edge.
- Reset mid-run: rst_n=0 at the edge after the second MUL, with start=1 on the same edge -> next cycle busy=0, done=0, result=0, ovf=0, state IDLE. No done pulse follows, and start is not accepted until rst_n returns to 1.
- NCOEF=1 build: c0=0x1234, start -> done after the accept edge, result=0x1234, busy never high.
